// File: rtl/grf_wb.sv
// grf_wb: MIPS general register file, 32 x WIDTH.
// Two combinational read ports and one synchronous write port.
// Optional same-cycle write-to-read forwarding.
// A registered one-cycle trace record is emitted for every committed write.
module grf_wb #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       RegAddr,
    input  logic [WIDTH-1:0] RegData,
    input  logic [31:0]      PC,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [WIDTH-1:0] trace_data
);

    // Storage. Index 0 is never written, so it stays at its reset value of 0.
    logic [WIDTH-1:0] r_regs [NREG];

    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [4:0]       r_trace_addr;
    logic [WIDTH-1:0] r_trace_data;

    // A write commits only outside reset and never to $0.
    // Gating with reset also stops a pending write from being forwarded
    // while reset is held.
    logic w_commit;
    assign w_commit = RegWrite && (RegAddr != 5'd0) && !reset;

    logic w_byp1;
    logic w_byp2;
    assign w_byp1 = (BYPASS != 0) && w_commit && (A1 == RegAddr);
    assign w_byp2 = (BYPASS != 0) && w_commit && (A2 == RegAddr);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic w_we;
            assign w_we = w_commit && (RegAddr == 5'(gi));

            // One register per generate instance, cleared asynchronously.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_regs[gi] <= '0;
                end else if (w_we) begin
                    r_regs[gi] <= RegData;
                end
            end
        end
    endgenerate

    // Read port 1: forwarded write data takes priority, and $0 always reads zero.
    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0) begin
            RD1 = w_byp1 ? RegData : r_regs[A1];
        end
    end

    // Read port 2: the same rules as read port 1, applied to A2.
    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0) begin
            RD2 = w_byp2 ? RegData : r_regs[A2];
        end
    end

    // Trace record: loads on each committed write.
    // Otherwise the valid bit drops and the fields hold their values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else if (w_commit) begin
            r_trace_valid <= 1'b1;
            r_trace_pc    <= PC;
            r_trace_addr  <= RegAddr;
            r_trace_data  <= RegData;
        end else begin
            r_trace_valid <= 1'b0;
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;

endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb: directed and randomized checks of grf_wb.
// Two instances are driven in parallel, one with forwarding enabled and one without.
module tb_grf_wb;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic [31:0] PC;
    logic [4:0]  A1;
    logic [4:0]  A2;

    logic [31:0] RD1_b, RD2_b, RD1_n, RD2_n;
    logic        tv_b, tv_n;
    logic [31:0] tpc_b, tpc_n;
    logic [4:0]  taddr_b, taddr_n;
    logic [31:0] tdata_b, tdata_n;

    int checks   = 0;
    int failures = 0;

    // Reference state: register contents plus the expected trace record.
    logic [31:0] mdl [32];
    logic        e_tv;
    logic [31:0] e_tpc;
    logic [4:0]  e_taddr;
    logic [31:0] e_tdata;

    grf_wb #(.WIDTH(32), .NREG(32), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RegAddr(RegAddr),
        .RegData(RegData), .PC(PC), .A1(A1), .A2(A2),
        .RD1(RD1_b), .RD2(RD2_b), .trace_valid(tv_b), .trace_pc(tpc_b),
        .trace_addr(taddr_b), .trace_data(tdata_b)
    );

    grf_wb #(.WIDTH(32), .NREG(32), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RegAddr(RegAddr),
        .RegData(RegData), .PC(PC), .A1(A1), .A2(A2),
        .RD1(RD1_n), .RD2(RD2_n), .trace_valid(tv_n), .trace_pc(tpc_n),
        .trace_addr(taddr_n), .trace_data(tdata_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Update the reference for one edge under the current inputs (no reset).
    task automatic model_edge();
        if (RegWrite && RegAddr != 0) begin
            mdl[RegAddr] = RegData;
            e_tv    = 1'b1;
            e_tpc   = PC;
            e_taddr = RegAddr;
            e_tdata = RegData;
        end else begin
            e_tv = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        e_tv = 1'b0; e_tpc = '0; e_taddr = '0; e_tdata = '0;
    endtask

    task automatic chk_trace(input string tag);
        chk({tag, "_tv"},    {31'd0, tv_b}, {31'd0, e_tv});
        chk({tag, "_tpc"},   tpc_b, e_tpc);
        chk({tag, "_taddr"}, {27'd0, taddr_b}, {27'd0, e_taddr});
        chk({tag, "_tdata"}, tdata_b, e_tdata);
        chk({tag, "_tv_n"},  {31'd0, tv_n}, {31'd0, e_tv});
    endtask

    // Write one register, leaving RegWrite low after the edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        RegWrite = 1'b1; RegAddr = a; RegData = d; PC = pc;
        model_edge();
        tick();
        RegWrite = 1'b0;
        $display("txn write r%0d=%h pc=%h", a, d, pc);
    endtask

    logic [31:0] exp1, exp2, expn1, expn2;

    initial begin
        reset = 1'b1; RegWrite = 1'b0; RegAddr = '0; RegData = '0; PC = '0; A1 = '0; A2 = '0;
        model_reset();

        // Reset held for two edges, then sweep every index on both ports.
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            chk("rst_rd1", RD1_b, 32'd0);
            chk("rst_rd2", RD2_b, 32'd0);
            chk("rst_rd1_n", RD1_n, 32'd0);
        end
        chk("rst_tv", {31'd0, tv_b}, 32'd0);
        $display("txn reset sweep");

        // Basic write then read, with a one-cycle trace pulse.
        do_write(5'd5, 32'h12345678, 32'h00003000);
        A1 = 5'd5; #1;
        chk("basic_rd1", RD1_b, 32'h12345678);
        chk("basic_rd1_n", RD1_n, 32'h12345678);
        chk("basic_tv", {31'd0, tv_b}, 32'd1);
        chk("basic_tpc", tpc_b, 32'h00003000);
        chk("basic_taddr", {27'd0, taddr_b}, 32'd5);
        chk("basic_tdata", tdata_b, 32'h12345678);
        model_edge(); tick();
        chk("basic_tv_drop", {31'd0, tv_b}, 32'd0);
        chk("basic_thold", tdata_b, 32'h12345678);

        // Writes to $0 are discarded and reads of $0 stay zero.
        RegWrite = 1'b1; RegAddr = 5'd0; RegData = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0; #1;
        chk("r0_during", RD1_b, 32'd0);
        chk("r0_during2", RD2_b, 32'd0);
        model_edge(); tick();
        chk("r0_after", RD1_b, 32'd0);
        chk("r0_tv", {31'd0, tv_b}, 32'd0);
        RegWrite = 1'b0;
        $display("txn write r0 discarded");

        // Same-cycle forwarding on both ports.
        do_write(5'd7, 32'h1, 32'h00003004);
        RegWrite = 1'b1; RegAddr = 5'd7; RegData = 32'hABCD0000; PC = 32'h00003008; A1 = 5'd7; A2 = 5'd7; #1;
        chk("byp_rd1", RD1_b, 32'hABCD0000);
        chk("byp_rd2", RD2_b, 32'hABCD0000);
        chk("nobyp_rd1", RD1_n, 32'h1);
        chk("nobyp_rd2", RD2_n, 32'h1);
        model_edge(); tick();
        RegWrite = 1'b0; #1;
        chk("nobyp_after", RD1_n, 32'hABCD0000);
        chk("byp_after", RD2_b, 32'hABCD0000);
        chk_trace("byp");
        $display("txn write r7=abcd0000 bypass");

        // Reset asserted between edges while a write to r31 is pending.
        do_write(5'd31, 32'h00003008, 32'h0000300C);
        A1 = 5'd31; #1;
        chk("pre_rst_r31", RD1_b, 32'h00003008);
        RegWrite = 1'b1; RegAddr = 5'd31; RegData = 32'h0000DEAD; PC = 32'h00003010;
        #2 reset = 1'b1;
        #1;
        chk("arst_rd1", RD1_b, 32'd0);
        chk("arst_rd1_n", RD1_n, 32'd0);
        chk("arst_tv", {31'd0, tv_b}, 32'd0);
        model_reset();
        tick();
        reset = 1'b0; RegWrite = 1'b0; #1;
        chk("arst_after_rd1", RD1_b, 32'd0);
        chk_trace("arst");
        $display("txn reset during pending write r31");

        // Back-to-back writes to r3; each produces its own trace pulse.
        RegWrite = 1'b1; RegAddr = 5'd3; RegData = 32'h10; PC = 32'h00003020;
        model_edge(); tick();
        chk_trace("b2b1");
        RegData = 32'h20; PC = 32'h00003024;
        model_edge(); tick();
        chk_trace("b2b2");
        RegWrite = 1'b0; A1 = 5'd3;
        model_edge(); tick();
        chk("b2b_rd", RD1_b, 32'h20);
        chk_trace("b2b3");
        $display("txn back-to-back r3=10,20");

        // Randomized traffic against the reference model.
        for (int t = 0; t < 300; t++) begin
            RegWrite = ($urandom_range(0, 3) != 0);
            RegAddr  = 5'($urandom_range(0, 31));
            RegData  = $urandom;
            PC       = $urandom;
            A1 = ($urandom_range(0, 2) == 0) ? RegAddr : 5'($urandom_range(0, 31));
            A2 = ($urandom_range(0, 2) == 0) ? RegAddr : 5'($urandom_range(0, 31));
            #1;
            expn1 = (A1 == 0) ? 32'd0 : mdl[A1];
            expn2 = (A2 == 0) ? 32'd0 : mdl[A2];
            exp1  = (RegWrite && RegAddr != 0 && A1 == RegAddr) ? RegData : expn1;
            exp2  = (RegWrite && RegAddr != 0 && A2 == RegAddr) ? RegData : expn2;
            chk("rnd_rd1", RD1_b, exp1);
            chk("rnd_rd2", RD2_b, exp2);
            chk("rnd_rd1_n", RD1_n, expn1);
            chk("rnd_rd2_n", RD2_n, expn2);
            $display("txn %0d we=%0b addr=%0d data=%h a1=%0d a2=%0d", t, RegWrite, RegAddr, RegData, A1, A2);
            model_edge();
            tick();
            chk_trace("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
